// File: rtl/rc5_pkg.sv
// Shared RC5 definitions: magic-constant helpers, mode and state encodings.
// The S-table init block and the key-mixing stage both import this package.
package rc5_pkg;

  typedef enum logic {
    MODE_SEED = 1'b0,
    MODE_CONT = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_GEN     = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // P_W = Odd((e - 2) * 2^W), zero-extended to 64 bits
  function automatic logic [63:0] p_of(input int w);
    case (w)
      16:      return 64'h0000_0000_0000_B7E1;
      32:      return 64'h0000_0000_B7E1_5163;
      default: return 64'hB7E1_5162_8AED_2A6B;
    endcase
  endfunction

  // Q_W = Odd((phi - 1) * 2^W), zero-extended to 64 bits
  function automatic logic [63:0] q_of(input int w);
    case (w)
      16:      return 64'h0000_0000_0000_9E37;
      32:      return 64'h0000_0000_9E37_79B9;
      default: return 64'h9E37_79B9_7F4A_7C15;
    endcase
  endfunction

endpackage

// File: rtl/rc5_magic_acc.sv
// W-bit magic-constant accumulator: load a seed, optionally stepping by QW
// in the same cycle, or step the held value by QW (modulo 2^W).
module rc5_magic_acc #(
  parameter int           W  = 32,
  parameter logic [W-1:0] QW = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] seed_i,
  output logic [W-1:0] acc_o
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;
  logic [W-1:0] base;

  always_comb begin
    base  = load_i ? seed_i : acc_q;
    acc_d = acc_q;
    if (load_i || step_i) begin
      acc_d = base + (step_i ? QW : {W{1'b0}});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= {W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/rc5_s_table_init.sv
// Fills S[0..T-1] of the external S RAM with P_W + i*Q_W, one word per cycle,
// either from scratch (SEED) or resuming from a word already in RAM (CONT).
module rc5_s_table_init
  import rc5_pkg::*;
#(
  parameter int           W        = 32,
  parameter int           T        = 26,
  parameter logic [W-1:0] PW       = W'(p_of(W)),
  parameter logic [W-1:0] QW       = W'(q_of(W)),
  localparam int          T_LENGTH = $clog2(T)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iStart,
  input  logic                iMode,
  input  logic [T_LENGTH-1:0] iBase,
  input  logic                iAbort,
  input  logic [W-1:0]        iS_sub_i,
  output logic [T_LENGTH-1:0] oS_address,
  output logic [W-1:0]        oS_sub_i_prima,
  output logic                oS_we,
  output logic                oS_re,
  output logic                oBusy,
  output logic                oDone,
  output logic                oErr
);

  if (!(W == 16 || W == 32 || W == 64)) begin : g_bad_w
    $error("rc5_s_table_init: W must be 16, 32 or 64");
  end
  if (T < 2) begin : g_bad_t
    $error("rc5_s_table_init: T must be at least 2");
  end

  localparam logic [T_LENGTH-1:0] LAST = T_LENGTH'(T - 1);

  state_e              state_q, state_d;
  logic [T_LENGTH-1:0] addr_q, addr_d;
  logic                we_q, we_d;
  logic                re_q, re_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                reject_q, reject_d;
  logic                acc_load, acc_step;
  logic [W-1:0]        acc_seed;
  logic [W-1:0]        acc_val;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    reject_d = reject_q;
    acc_load = 1'b0;
    acc_step = 1'b0;
    acc_seed = PW;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (iStart && !iAbort) begin
          busy_d = 1'b1;
          done_d = 1'b0;
          err_d  = 1'b0;
          if (mode_e'(iMode) == MODE_SEED) begin
            state_d  = ST_GEN;
            we_d     = 1'b1;
            addr_d   = '0;
            acc_load = 1'b1;
          end else if (iBase >= LAST) begin
            // Nothing after iBase to fill: spend one cycle, then report the error.
            state_d  = ST_RD_REQ;
            reject_d = 1'b1;
          end else begin
            state_d  = ST_RD_REQ;
            re_d     = 1'b1;
            addr_d   = iBase;
          end
        end
      end
      ST_RD_REQ: begin
        if (reject_q) begin
          state_d  = ST_DONE;
          busy_d   = 1'b0;
          err_d    = 1'b1;
          reject_d = 1'b0;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        // Read data is valid now; the first write is seed + QW.
        state_d  = ST_GEN;
        we_d     = 1'b1;
        addr_d   = addr_q + T_LENGTH'(1);
        acc_load = 1'b1;
        acc_step = 1'b1;
        acc_seed = iS_sub_i;
      end
      ST_GEN: begin
        if (addr_q == LAST) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          we_d     = 1'b1;
          addr_d   = addr_q + T_LENGTH'(1);
          acc_step = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (iAbort && (state_q inside {ST_RD_REQ, ST_RD_WAIT, ST_GEN})) begin
      state_d  = ST_IDLE;
      addr_d   = addr_q;
      we_d     = 1'b0;
      re_d     = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      reject_d = 1'b0;
      acc_load = 1'b0;
      acc_step = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      re_q     <= re_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      reject_q <= reject_d;
    end
  end

  rc5_magic_acc #(
    .W  (W),
    .QW (QW)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .load_i (acc_load),
    .step_i (acc_step),
    .seed_i (acc_seed),
    .acc_o  (acc_val)
  );

  assign oS_address     = addr_q;
  assign oS_sub_i_prima = acc_val;
  assign oS_we          = we_q;
  assign oS_re          = re_q;
  assign oBusy          = busy_q;
  assign oDone          = done_q;
  assign oErr           = err_q;

endmodule

// File: tb/tb_rc5_s_table_init.sv
// Bench for rc5_s_table_init: a W=32/T=26 instance with a golden RAM model and
// a W=16/T=4 instance; every write is checked against an expected queue.
module tb_rc5_s_table_init;

  localparam logic [31:0] PW32 = 32'hB7E15163;
  localparam logic [31:0] QW32 = 32'h9E3779B9;

  logic        clk = 1'b0;
  logic        rst;

  logic        start32, mode32, abort32;
  logic [4:0]  base32;
  logic [31:0] rdata32;
  logic [4:0]  addr32;
  logic [31:0] data32;
  logic        we32, re32, busy32, done32, err32;

  logic        start16;
  logic [1:0]  addr16;
  logic [15:0] data16;
  logic        we16, re16, busy16, done16, err16;

  logic [31:0] ram32 [0:25];
  logic        preload;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;

  logic [36:0] exp32_q[$];
  logic [17:0] exp16_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int wr_cnt32 = 0;
  int re_cnt32 = 0;
  int wr_cnt16 = 0;

  always #5 clk = ~clk;

  rc5_s_table_init dut32 (
    .clk            (clk),
    .rst            (rst),
    .iStart         (start32),
    .iMode          (mode32),
    .iBase          (base32),
    .iAbort         (abort32),
    .iS_sub_i       (rdata32),
    .oS_address     (addr32),
    .oS_sub_i_prima (data32),
    .oS_we          (we32),
    .oS_re          (re32),
    .oBusy          (busy32),
    .oDone          (done32),
    .oErr           (err32)
  );

  rc5_s_table_init #(.W(16), .T(4)) dut16 (
    .clk            (clk),
    .rst            (rst),
    .iStart         (start16),
    .iMode          (1'b0),
    .iBase          (2'b00),
    .iAbort         (1'b0),
    .iS_sub_i       (16'h0000),
    .oS_address     (addr16),
    .oS_sub_i_prima (data16),
    .oS_we          (we16),
    .oS_re          (re16),
    .oBusy          (busy16),
    .oDone          (done16),
    .oErr           (err16)
  );

  // Golden S RAM: 1-cycle read latency, bench-side preload port
  always @(posedge clk) begin
    if (preload) begin
      ram32[pl_addr] <= pl_data;
    end else if (we32) begin
      ram32[addr32] <= data32;
    end
    if (re32) begin
      rdata32 <= ram32[addr32];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  always @(negedge clk) begin : mon32
    logic [36:0] e;
    check("we_re_exclusive32", 64'(we32 & re32), 64'd0);
    if (re32) re_cnt32++;
    if (we32) begin
      wr_cnt32++;
      check("write_expected32", 64'(exp32_q.size() != 0), 64'd1);
      if (exp32_q.size() != 0) begin
        e = exp32_q.pop_front();
        check("write32", {addr32, data32}, e);
      end
    end
  end

  always @(negedge clk) begin : mon16
    logic [17:0] e;
    if (we16) begin
      wr_cnt16++;
      check("write_expected16", 64'(exp16_q.size() != 0), 64'd1);
      if (exp16_q.size() != 0) begin
        e = exp16_q.pop_front();
        check("write16", {addr16, data16}, e);
      end
    end
  end

  task automatic push_seed32(input int n);
    logic [31:0] v;
    v = PW32;
    for (int i = 0; i < n; i++) begin
      exp32_q.push_back({5'(i), v});
      v = v + QW32;
    end
  endtask

  task automatic push_cont32(input int base, input logic [31:0] seed);
    logic [31:0] v;
    v = seed + QW32;
    for (int a = base + 1; a < 26; a++) begin
      exp32_q.push_back({5'(a), v});
      v = v + QW32;
    end
  endtask

  task automatic pulse32(input logic m, input logic [4:0] b);
    start32 = 1'b1;
    mode32  = m;
    base32  = b;
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic pulse16();
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
  endtask

  initial begin
    logic [31:0] s4, s25;
    s4  = PW32 + 32'd4 * QW32;
    s25 = PW32 + 32'd25 * QW32;
    rst = 1'b0; start32 = 1'b0; mode32 = 1'b0; abort32 = 1'b0; base32 = '0;
    start16 = 1'b0; preload = 1'b0; pl_addr = '0; pl_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out32", {we32, re32, busy32, done32, err32, addr32, data32}, 64'd0);
    check("rst_out16", {we16, re16, busy16, done16, err16, addr16, data16}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // SEED fill, W=32 T=26
    push_seed32(26);
    wr_cnt32 = 0;
    pulse32(1'b0, 5'd0);
    check("t1_first", {we32, busy32, addr32, data32}, {1'b1, 1'b1, 5'd0, PW32});
    repeat (25) @(negedge clk);
    check("t1_last", {we32, addr32}, {1'b1, 5'd25});
    @(negedge clk);
    check("t1_done", {done32, busy32, we32, err32}, 4'b1000);
    check("t1_nwr", wr_cnt32, 26);
    check("t1_qempty", exp32_q.size(), 0);
    check("t1_s1", ram32[1], 32'h5618CB1C);
    check("t1_s25", ram32[25], s25);

    // SEED fill, W=16 T=4 (carry dropped)
    exp16_q.push_back({2'd0, 16'hB7E1});
    exp16_q.push_back({2'd1, 16'h5618});
    exp16_q.push_back({2'd2, 16'hF44F});
    exp16_q.push_back({2'd3, 16'h9286});
    pulse16();
    check("t2_first", {we16, busy16, addr16, data16}, {1'b1, 1'b1, 2'd0, 16'hB7E1});
    repeat (3) @(negedge clk);
    check("t2_last", {we16, addr16, data16}, {1'b1, 2'd3, 16'h9286});
    @(negedge clk);
    check("t2_done", {done16, busy16, we16, err16}, 4'b1000);
    check("t2_nwr", wr_cnt16, 4);

    // CONT from iBase=10 with RAM[10]=0
    preload = 1'b1; pl_addr = 5'd10; pl_data = 32'h0;
    @(negedge clk);
    preload = 1'b0;
    push_cont32(10, 32'h0);
    wr_cnt32 = 0; re_cnt32 = 0;
    pulse32(1'b1, 5'd10);
    check("t3_read", {re32, we32, busy32, done32, addr32}, {1'b1, 1'b0, 1'b1, 1'b0, 5'd10});
    @(negedge clk);
    check("t3_wait", {re32, we32, busy32}, 3'b001);
    @(negedge clk);
    check("t3_first", {we32, re32, addr32, data32}, {1'b1, 1'b0, 5'd11, 32'h9E3779B9});
    repeat (14) @(negedge clk);
    check("t3_last", {we32, addr32}, {1'b1, 5'd25});
    @(negedge clk);
    check("t3_done", {done32, busy32, err32}, 3'b100);
    check("t3_nwr", wr_cnt32, 15);
    check("t3_nre", re_cnt32, 1);

    // CONT rejected: iBase = T-1
    wr_cnt32 = 0; re_cnt32 = 0;
    pulse32(1'b1, 5'd25);
    check("t4_accept", {busy32, done32, err32, re32, we32}, 5'b10000);
    @(negedge clk);
    check("t4_err", {busy32, done32, err32, re32, we32}, 5'b00100);
    repeat (2) @(negedge clk);
    check("t4_nwr", wr_cnt32, 0);
    check("t4_nre", re_cnt32, 0);

    // Abort at the 5th write, then a fresh fill
    push_seed32(5);
    wr_cnt32 = 0;
    pulse32(1'b0, 5'd0);
    repeat (4) @(negedge clk);
    check("t5_fifth", {we32, addr32}, {1'b1, 5'd4});
    abort32 = 1'b1;
    @(negedge clk);
    abort32 = 1'b0;
    check("t5_aborted", {we32, re32, busy32, done32, err32}, 5'b00000);
    check("t5_s4", ram32[4], s4);
    check("t5_nwr", wr_cnt32, 5);
    @(negedge clk);
    check("t5_idle", {we32, busy32}, 2'b00);
    push_seed32(26);
    wr_cnt32 = 0;
    pulse32(1'b0, 5'd0);
    check("t5_refill", {we32, addr32, data32}, {1'b1, 5'd0, PW32});
    repeat (26) @(negedge clk);
    check("t5_done", {done32, busy32}, 2'b10);
    check("t5_nwr", wr_cnt32, 26);

    // Start pulses while busy are ignored
    push_seed32(26);
    wr_cnt32 = 0; re_cnt32 = 0;
    pulse32(1'b0, 5'd0);
    repeat (3) @(negedge clk);
    pulse32(1'b1, 5'd3);
    repeat (21) @(negedge clk);
    check("t6_busy_last", {we32, addr32}, {1'b1, 5'd25});
    @(negedge clk);
    check("t6_done", {done32, busy32}, 2'b10);
    check("t6_nwr", wr_cnt32, 26);
    check("t6_nre", re_cnt32, 0);

    // Start and abort together while idle: request dropped
    start32 = 1'b1; abort32 = 1'b1; mode32 = 1'b0;
    @(negedge clk);
    start32 = 1'b0; abort32 = 1'b0;
    check("t6_abort_wins", {busy32, we32, done32}, 3'b001);

    // Reset mid-fill
    push_seed32(4);
    wr_cnt32 = 0;
    pulse32(1'b0, 5'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_out32", {we32, re32, busy32, done32, err32, addr32, data32}, 64'd0);
    check("t6_rst_out16", {we16, re16, busy16, done16, err16, addr16, data16}, 64'd0);
    check("t6_rst_nwr", wr_cnt32, 4);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_post_rst", {we32, re32, busy32, done32, err32}, 5'b00000);
    check("t6_qempty", exp32_q.size() + exp16_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
